// File: rtl/pong_frame_scheduler.sv
// pong_frame_scheduler
//
// Purpose: opens a fixed-length update window at each vsync falling edge and
// hands it out to up to N_REQ requesters (paddles, ball, score) one at a time.
// Each requester gets at most one slot per window. Every slot is bounded by
// SLOT_MAX clocks. A slot is only granted when the rest of the window can hold a
// full SLOT_MAX slot, so game-state writes never spill into active video.
//
// Handshake: req is a level request. gnt is one-hot, and rises one clock after
// a SCAN cycle accepts the request. The requester returns a done strobe
// (sampled only on its granted bit). gnt falls on the edge that samples done,
// or on the edge that samples the slot's last cycle (timeout). Holding req
// after that edge does not earn a second slot in the same window.
//
// Optional feature: define FRAME_SCHED_FAIR_EN to rotate the first-priority
// requester by one at every window close. Without it requester 0 is always
// scanned first.
//
// Ports:
//   clk          pixel clock (same clock as the VGA timing)
//   reset_n      asynchronous active-low reset
//   vsync        vertical sync from the VGA timing, active low
//   req[N]       level request per requester
//   done[N]      completion strobe, looked at only on the granted bit
//   err_clr      clears err_mask (a same-cycle timeout still sets its bit)
//   gnt[N]       one-hot grant or all zero
//   busy         high while the window is open
//   window_end   one-clock pulse when the window closes
//   timeout      one-clock pulse when a slot expires without done
//   err_mask[N]  sticky per-requester timeout flags
//   frame_count  completed windows, wraps 65535 -> 0

module pong_frame_scheduler #(
    parameter int N_REQ         = 4,
    parameter int WINDOW_CYCLES = 28000,
    parameter int SLOT_MAX      = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vsync,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic             err_clr,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             window_end,
    output logic             timeout,
    output logic [N_REQ-1:0] err_mask,
    output logic [15:0]      frame_count
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    start_ptr;
    logic             vsync_q;
    // One bit wider than the window so it cannot wrap, even when a grant
    // accepted at the last legal point runs to the window's final clock.
    logic [16:0]      win_cnt;
    logic [15:0]      slot_cnt;
    logic [N_REQ-1:0] served;

    logic vsync_fall;
    logic room_left;
    logic win_last;
    logic slot_last;

    assign vsync_fall = vsync_q & ~vsync;
    // WINDOW_CYCLES - win_cnt >= SLOT_MAX, rearranged to avoid underflow.
    assign room_left  = (win_cnt <= 17'(WINDOW_CYCLES - SLOT_MAX));
    // >= rather than == so a window that ran to its very last clock still closes.
    assign win_last   = (win_cnt >= 17'(WINDOW_CYCLES - 1));
    assign slot_last  = (slot_cnt == 16'(SLOT_MAX - 1));

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(N_REQ - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            start_ptr   <= '0;
            vsync_q     <= 1'b1;
            win_cnt     <= '0;
            slot_cnt    <= '0;
            served      <= '0;
            gnt         <= '0;
            busy        <= 1'b0;
            window_end  <= 1'b0;
            timeout     <= 1'b0;
            err_mask    <= '0;
            frame_count <= '0;
        end else begin
            vsync_q    <= vsync;
            window_end <= 1'b0;
            timeout    <= 1'b0;

            // A timeout bit set further down overrides this clear.
            if (err_clr) begin
                err_mask <= '0;
            end

            if (busy) begin
                win_cnt <= win_cnt + 17'd1;
            end

            case (state)
                IDLE: begin
                    if (vsync_fall) begin
                        state   <= SCAN;
                        busy    <= 1'b1;
                        win_cnt <= '0;
                        served  <= '0;
                        ptr     <= start_ptr;
                    end
                end

                SCAN: begin
                    // Closing outranks a grant in the same cycle.
                    if (win_last) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        window_end  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
`ifdef FRAME_SCHED_FAIR_EN
                        start_ptr   <= next_ptr(start_ptr);
`else
                        start_ptr   <= '0;
`endif
                    end else if (req[ptr] && !served[ptr] && room_left) begin
                        state    <= GRANT;
                        gnt      <= N_REQ'(1) << ptr;
                        slot_cnt <= '0;
                    end else begin
                        ptr <= next_ptr(ptr);
                    end
                end

                GRANT: begin
                    if (done[ptr] || slot_last) begin
                        state       <= SCAN;
                        gnt         <= '0;
                        served[ptr] <= 1'b1;
                        ptr         <= next_ptr(ptr);
                        // done on the last slot cycle still counts as done.
                        if (!done[ptr]) begin
                            timeout       <= 1'b1;
                            err_mask[ptr] <= 1'b1;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_frame_scheduler.sv
// tb_pong_frame_scheduler
//
// Two instances: dut (N_REQ=4, WINDOW_CYCLES=100, SLOT_MAX=20) for most
// scenarios and dut_b (WINDOW_CYCLES=30) for the frame-to-frame priority
// scenario. Inputs change on the falling clock edge, outputs are sampled there.
// Expected grants go into exp_q when stimulus is driven; grants seen on gnt go
// into obs_q and are popped against exp_q.

module tb_pong_frame_scheduler;

    localparam int N  = 4;
    localparam int W  = 100;
    localparam int S  = 20;
    localparam int WB = 30;

    // ---------------- clock / reset / signals ----------------
    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         vsync   = 1'b1;
    logic         vsync_b = 1'b1;
    logic         err_clr = 1'b0;
    logic [N-1:0] req     = '0;
    logic [N-1:0] done    = '0;
    logic [N-1:0] req_b   = '0;
    logic [N-1:0] done_b  = '0;

    logic [N-1:0] gnt, gnt_b;
    logic         busy, busy_b;
    logic         window_end, window_end_b;
    logic         timeout, timeout_b;
    logic [N-1:0] err_mask, err_mask_b;
    logic [15:0]  frame_count, frame_count_b;

    initial begin
        forever #5 clk = ~clk;
    end

    pong_frame_scheduler #(.N_REQ(N), .WINDOW_CYCLES(W), .SLOT_MAX(S)) dut (
        .clk(clk), .reset_n(reset_n), .vsync(vsync), .req(req), .done(done),
        .err_clr(err_clr), .gnt(gnt), .busy(busy), .window_end(window_end),
        .timeout(timeout), .err_mask(err_mask), .frame_count(frame_count)
    );

    pong_frame_scheduler #(.N_REQ(N), .WINDOW_CYCLES(WB), .SLOT_MAX(S)) dut_b (
        .clk(clk), .reset_n(reset_n), .vsync(vsync_b), .req(req_b), .done(done_b),
        .err_clr(err_clr), .gnt(gnt_b), .busy(busy_b), .window_end(window_end_b),
        .timeout(timeout_b), .err_mask(err_mask_b), .frame_count(frame_count_b)
    );

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    int           exp_frames = 0;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] obs_q[$];

    // ---------------- driver task ----------------
    // Opens one window on dut, raises req=r at window cycle req_at (0 = with
    // the vsync fall), returns done after 'hold' grant clocks (0 = never) and
    // runs until window_end. Grants seen are pushed to obs_q.
    task automatic run_window(input logic [N-1:0] r, input int req_at, input int hold,
                              output int busy_cyc, output int we_cnt, output int to_cnt,
                              output int bad_oh, output int last_len,
                              output int first_gnt_cyc, output bit expired);
        logic [N-1:0] prev;
        int len;
        int cyc;
        busy_cyc = 0; we_cnt = 0; to_cnt = 0; bad_oh = 0; last_len = 0;
        first_gnt_cyc = -1; expired = 1'b1; prev = '0; len = 0; cyc = 0;
        @(negedge clk);
        vsync = 1'b0;
        if (req_at == 0) req = r;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 3) vsync = 1'b1;
            if (cyc == req_at) req = r;
            if (busy) busy_cyc++;
            if (timeout) to_cnt++;
            if (gnt != '0 && !$onehot(gnt)) bad_oh++;
            if (gnt != '0 && prev == '0) begin
                obs_q.push_back(gnt);
                len = 0;
                if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            end
            if (gnt != '0) len++;
            if (gnt == '0 && prev != '0) last_len = len;
            done = (hold > 0 && gnt != '0 && len == hold) ? gnt : '0;
            prev = gnt;
            if (window_end) begin
                we_cnt++;
                expired = 1'b0;
                break;
            end
        end
        req  = '0;
        done = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (window_end) we_cnt++;
            if (busy) busy_cyc++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int bc, we, to, oh, ll, fg;
        bit ex;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({gnt, busy, window_end, timeout, err_mask, frame_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got gnt=%b busy=%b we=%b to=%b err=%b fc=%0d, want all 0",
                     gnt, busy, window_end, timeout, err_mask, frame_count);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // One empty window so frame_count is non-zero before the reset.
        obs_q.delete();
        run_window('0, 0, 0, bc, we, to, oh, ll, fg, ex);
        exp_frames = 1;
        n_checks++;
        if (ex || frame_count !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL reset_pre_frame: got fc=%0d expired=%0d, want %0d", frame_count, ex, exp_frames);
        end

        // Open a window, wait for the grant, then pull reset mid-grant.
        @(negedge clk);
        vsync = 1'b0;
        req   = 4'b0001;
        for (int i = 0; i < 10 && gnt == '0; i++) @(negedge clk);
        vsync = 1'b1;
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_setup_grant: got %b, want 0001", gnt);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== '0) begin
            n_fail++;
            $display("FAIL reset_async_gnt: got %b, want 0000", gnt);
        end
        n_checks++;
        if ({busy, window_end, timeout, err_mask, frame_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_grant: got busy=%b we=%b to=%b err=%b fc=%0d, want all 0",
                     busy, window_end, timeout, err_mask, frame_count);
        end
        exp_frames = 0;
        req = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int bc, we, to, oh, ll, fg;
        bit ex;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back(4'b0010);
        run_window(4'b0010, 0, 5, bc, we, to, oh, ll, fg, ex);
        exp_frames++;
        n_checks++;
        if (ex) begin n_fail++; $display("FAIL single_expired: no window_end within bound"); end
        n_checks++;
        if (obs_q.size() != 1 || obs_q.pop_front() !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL single_grant: wrong grant, want one grant of 0010");
        end
        n_checks++;
        if (fg != 3) begin n_fail++; $display("FAIL single_latency: grant at cycle %0d, want 3", fg); end
        n_checks++;
        if (ll != 5) begin n_fail++; $display("FAIL single_hold: gnt high %0d, want 5", ll); end
        n_checks++;
        if (bc != W) begin n_fail++; $display("FAIL single_busy: busy %0d clocks, want %0d", bc, W); end
        n_checks++;
        if (we != 1 || to != 0) begin
            n_fail++; $display("FAIL single_pulses: window_end=%0d timeout=%0d, want 1 and 0", we, to);
        end
        n_checks++;
        if (frame_count !== 16'(exp_frames)) begin
            n_fail++; $display("FAIL single_frames: got %0d, want %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_all_four();
        int bc, we, to, oh, ll, fg;
        bit ex;
        logic [N-1:0] e, o;
        obs_q.delete(); exp_q.delete();
        for (int k = 0; k < N; k++) exp_q.push_back(4'(1 << k));
        run_window(4'b1111, 0, 10, bc, we, to, oh, ll, fg, ex);
        exp_frames++;
        n_checks++;
        if (ex) begin n_fail++; $display("FAIL four_expired: no window_end within bound"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL four_order: got %b, want %b", o, e); end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++; $display("FAIL four_extra: %0d extra grants, want 0", obs_q.size());
        end
        n_checks++;
        if (oh != 0 || ll != 10 || to != 0) begin
            n_fail++; $display("FAIL four_shape: non-onehot=%0d last_len=%0d timeouts=%0d, want 0/10/0", oh, ll, to);
        end
        n_checks++;
        if (frame_count !== 16'(exp_frames)) begin
            n_fail++; $display("FAIL four_frames: got %0d, want %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_timeout();
        int bc, we, to, oh, ll, fg;
        bit ex;
        obs_q.delete(); exp_q.delete();
        exp_q.push_back(4'b0100);
        run_window(4'b0100, 0, 0, bc, we, to, oh, ll, fg, ex);
        exp_frames++;
        n_checks++;
        if (ex || obs_q.size() != 1 || obs_q.pop_front() !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL timeout_grant: want a single grant of 0100 (expired=%0d)", ex);
        end
        n_checks++;
        if (ll != S) begin n_fail++; $display("FAIL timeout_len: gnt high %0d, want %0d", ll, S); end
        n_checks++;
        if (to != 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d pulses, want 1", to); end
        n_checks++;
        if (err_mask !== 4'b0100) begin n_fail++; $display("FAIL timeout_err: got %b, want 0100", err_mask); end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        n_checks++;
        if (err_mask !== '0) begin n_fail++; $display("FAIL timeout_clr: got %b, want 0000", err_mask); end
    endtask

    task automatic test_window_budget();
        int bc, we, to, oh, ll, fg;
        bit ex;
        // Exactly SLOT_MAX clocks left (win_cnt=80): still granted.
        obs_q.delete();
        run_window(4'b0001, 81, 5, bc, we, to, oh, ll, fg, ex);
        exp_frames++;
        n_checks++;
        if (ex || fg != 82 || bc != W) begin
            n_fail++; $display("FAIL budget_edge: grant cycle %0d busy %0d expired %0d, want 82/%0d/0", fg, bc, ex, W);
        end
        // Requester 0 first scanned at win_cnt=84: 16 left, refused.
        obs_q.delete();
        run_window(4'b0001, 82, 5, bc, we, to, oh, ll, fg, ex);
        exp_frames++;
        n_checks++;
        if (ex || fg != -1 || obs_q.size() != 0) begin
            n_fail++; $display("FAIL budget_refuse: grant cycle %0d grants %0d, want none", fg, obs_q.size());
        end
        n_checks++;
        if (bc != W || we != 1) begin
            n_fail++; $display("FAIL budget_close: busy %0d window_end %0d, want %0d/1", bc, we, W);
        end
        n_checks++;
        if (frame_count !== 16'(exp_frames)) begin
            n_fail++; $display("FAIL budget_frames: got %0d, want %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] first;
        logic [N-1:0] e;
        bit seen_end;
        exp_q.delete(); obs_q.delete();
        for (int f = 0; f < 3; f++) begin
`ifdef FRAME_SCHED_FAIR_EN
            exp_q.push_back(4'(1 << f));
`else
            exp_q.push_back(4'b0001);
`endif
        end
        for (int f = 0; f < 3; f++) begin
            first = '0;
            seen_end = 1'b0;
            @(negedge clk);
            vsync_b = 1'b0;
            req_b   = 4'b1111;
            for (int i = 1; i < 100; i++) begin
                @(negedge clk);
                if (i == 3) vsync_b = 1'b1;
                if (gnt_b != '0 && first == '0) first = gnt_b;
                if (window_end_b) begin seen_end = 1'b1; break; end
            end
            obs_q.push_back(first);
            req_b = '0;
            repeat (3) @(negedge clk);
            n_checks++;
            if (!seen_end) begin n_fail++; $display("FAIL fair_expired: frame %0d did not close", f); end
        end
        for (int f = 0; f < 3; f++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.pop_front() !== e) begin
                n_fail++; $display("FAIL fair_first_%0d: wrong first grant, want %b", f, e);
            end
        end
        n_checks++;
        if (frame_count_b !== 16'd3) begin
            n_fail++; $display("FAIL fair_frames: got %0d, want 3", frame_count_b);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_timeout();
        test_window_budget();
        test_fairness();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
